can_tx_scheduler: RTL

Shares the single transmit channel of the CAN packet engine among NREQ requesters. A round-robin grant picks one requester, whose 64-bit payload is latched and presented to the engine. The scheduler holds the engine's start request until the frame completes. It retries non-acknowledged frames, applies a watchdog timeout, and returns one completion report per accepted request. It sits between the bus-side request sources and the engine's tx_start/tx_data/tx_done/tx_acked ports.

---
 rtl/can_tx_scheduler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/can_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : can_tx_scheduler
// Description : Round-robin scheduler that shares one CAN packet-engine
//               transmit channel among NREQ requesters. It latches the granted
//               payload, holds tx_start until the frame ends, retries NACKed
//               frames after a gap, aborts on a per-attempt watchdog and
//               emits one completion report per accepted request.
// Ports       : clk, rst                  - clock / sync active-high reset
//               enable                    - allow new grants (sampled in IDLE)
//               req_valid/req_data        - requester payloads (64b each)
//               req_ready                 - one-hot accept strobe (comb.)
//               cpl_valid/cpl_src/cpl_status - one-cycle completion report
//               busy                      - scheduler not idle
//               tx_start/tx_data          - engine start request and payload
//               tx_done/tx_acked          - engine end-of-frame and ACK flag
// Revision    : 1.0 - initial release
// ============================================================================
module can_tx_scheduler #(
    parameter int NREQ        = 4,
    parameter int MAX_RETRY   = 3,
    parameter int GAP_CYC     = 16,
    parameter int TIMEOUT_CYC = 100000,
    localparam int SW         = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*64-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 cpl_valid,
    output logic [SW-1:0]        cpl_src,
    output logic [1:0]           cpl_status,
    output logic                 busy,
    output logic                 tx_start,
    output logic [63:0]          tx_data,
    input  logic                 tx_done,
    input  logic                 tx_acked
);

    // Widths sized so MAX_RETRY=0 and GAP_CYC=1 still give >=1-bit counters.
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int GW = $clog2(GAP_CYC + 1);

    localparam logic [1:0] ST_ACKED   = 2'b00;
    localparam logic [1:0] ST_NACK    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        GAP    = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t          state;
    logic [SW-1:0]   rr_ptr;
    logic [SW-1:0]   src;
    logic [RW-1:0]   retry_cnt;
    logic [31:0]     timer;
    logic [GW-1:0]   gap_cnt;

    logic            grant_found;
    logic [SW-1:0]   grant_idx;
    int              scan_idx;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = (int'(rr_ptr) + k) % NREQ;
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = SW'(scan_idx);
            end
        end
    end

    logic handshake;
    assign handshake = (state == IDLE) && enable && grant_found;
    assign req_ready = handshake ? (NREQ'(1) << grant_idx) : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            cpl_valid  <= 1'b0;
            cpl_src    <= '0;
            cpl_status <= '0;
            rr_ptr     <= '0;
            src        <= '0;
            retry_cnt  <= '0;
            timer      <= '0;
            gap_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        tx_data   <= req_data[64*grant_idx +: 64];
                        src       <= grant_idx;
                        rr_ptr    <= (grant_idx == SW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
                        retry_cnt <= '0;
                        timer     <= '0;
                        tx_start  <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    timer <= timer + 32'd1;
                    // tx_done is checked before the watchdog so a frame that
                    // ends on the last allowed cycle still reports its result.
                    if (tx_done && tx_acked) begin
                        tx_start   <= 1'b0;
                        cpl_valid  <= 1'b1;
                        cpl_src    <= src;
                        cpl_status <= ST_ACKED;
                        state      <= REPORT;
                    end else if (tx_done && (retry_cnt == RW'(MAX_RETRY))) begin
                        tx_start   <= 1'b0;
                        cpl_valid  <= 1'b1;
                        cpl_src    <= src;
                        cpl_status <= ST_NACK;
                        state      <= REPORT;
                    end else if (tx_done) begin
                        tx_start  <= 1'b0;
                        retry_cnt <= retry_cnt + 1'b1;
                        gap_cnt   <= '0;
                        state     <= GAP;
                    end else if (timer == 32'(TIMEOUT_CYC - 1)) begin
                        tx_start   <= 1'b0;
                        cpl_valid  <= 1'b1;
                        cpl_src    <= src;
                        cpl_status <= ST_TIMEOUT;
                        state      <= REPORT;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_cnt == GW'(GAP_CYC - 1)) begin
                        timer    <= '0;
                        tx_start <= 1'b1;
                        state    <= SEND;
                    end
                end
                REPORT: begin
                    cpl_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
